hbox3_filter_stage: RTL and testbench

Downstream consumer of the fifo_shell pixel chain. Takes a raster pixel stream over the chain's valid/ready handshake and outputs a 3-tap horizontal box sum per pixel, with left and right edge replication at line boundaries. The result goes to the next stage through the same handshake through a single registered output slot. Line structure comes from an internal column counter; the stream carries no sideband markers.

---
 rtl/hbox3_filter_stage.sv | 111 +++++++++++
 tb/tb_hbox3_filter_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hbox3_filter_stage.sv
// 3-tap horizontal box filter on a raster pixel stream, with edge replication
// at both ends of each line and a single registered output slot.
module hbox3_filter_stage #(
  parameter int DATA_WIDTH = 2,
  parameter int LINE_WIDTH = 4,
  parameter int COL_W      = $clog2(LINE_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  u_i_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  i_i_ready,
  input  logic                  u_r_ready,
  output logic [DATA_WIDTH+1:0] data_out,
  output logic                  i_r_ready,
  output logic                  eol_out
);

  localparam int SW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [COL_W-1:0]      col, col_nxt;
  logic [DATA_WIDTH-1:0] prev, prev_nxt;
  logic [DATA_WIDTH-1:0] cur, cur_nxt;
  logic [SW-1:0]         data_nxt;
  logic                  valid_nxt;
  logic                  eol_nxt;
  logic                  advance;
  logic                  accept;
  logic [SW-1:0]         sum_run;
  logic [SW-1:0]         sum_flush;

  // The output slot can take a new result when empty or draining this cycle.
  assign advance   = !i_r_ready || u_r_ready;
  assign i_i_ready = advance && (state != FLUSH);
  assign accept    = u_i_ready && i_i_ready;

  assign sum_run   = SW'(prev) + SW'(cur) + SW'(data_in);
  assign sum_flush = SW'(prev) + (SW'(cur) << 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      prev      <= '0;
      cur       <= '0;
      data_out  <= '0;
      i_r_ready <= 1'b0;
      eol_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      prev      <= prev_nxt;
      cur       <= cur_nxt;
      data_out  <= data_nxt;
      i_r_ready <= valid_nxt;
      eol_out   <= eol_nxt;
    end
  end

  // Column c is emitted when pixel c+1 arrives; the last column is emitted
  // from FLUSH using the right-edge pixel twice.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    prev_nxt  = prev;
    cur_nxt   = cur;
    data_nxt  = data_out;
    eol_nxt   = eol_out;
    valid_nxt = i_r_ready;
    if (advance) valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          cur_nxt   = data_in;
          prev_nxt  = data_in;
          col_nxt   = COL_W'(1);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          data_nxt  = sum_run;
          eol_nxt   = 1'b0;
          valid_nxt = 1'b1;
          prev_nxt  = cur;
          cur_nxt   = data_in;
          if (col == COL_W'(LINE_WIDTH - 1)) begin
            col_nxt   = '0;
            state_nxt = FLUSH;
          end else begin
            col_nxt = col + COL_W'(1);
          end
        end
      end
      FLUSH: begin
        if (advance) begin
          data_nxt  = sum_flush;
          eol_nxt   = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hbox3_filter_stage.sv
// Scoreboard bench for hbox3_filter_stage: expected line sums are queued as
// each line is driven and compared as the DUT hands results downstream.
module tb_hbox3_filter_stage;

  localparam int DW = 2;
  localparam int LW = 4;
  localparam int OW = DW + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          u_i_ready;
  logic [DW-1:0] data_in;
  logic          i_i_ready;
  logic          u_r_ready;
  logic [OW-1:0] data_out;
  logic          i_r_ready;
  logic          eol_out;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          eol;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   num_checks = 0;
  int   num_passed = 0;
  bit   stop_rand;
  int   w;
  int   stall_n;
  logic [DW-1:0] line_px [LW];

  hbox3_filter_stage #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
    .clock     (clock),
    .reset     (reset),
    .u_i_ready (u_i_ready),
    .data_in   (data_in),
    .i_i_ready (i_i_ready),
    .u_r_ready (u_r_ready),
    .data_out  (data_out),
    .i_r_ready (i_r_ready),
    .eol_out   (eol_out)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed === expected) num_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
  endtask

  // Reference: each column sums its neighbours, replicating pixels at the edges.
  task automatic push_line(input logic [DW-1:0] px [LW]);
    exp_t e;
    logic [DW-1:0] l, r;
    for (int c = 0; c < LW; c++) begin
      l = (c == 0) ? px[0] : px[c-1];
      r = (c == LW - 1) ? px[LW-1] : px[c+1];
      e.data = OW'(l) + OW'(px[c]) + OW'(r);
      e.eol  = (c == LW - 1);
      sb.push_back(e);
    end
  endtask

  // Presents one pixel after 'gap' idle cycles and holds it until accepted.
  task automatic applyStimulus(input logic [DW-1:0] px, input int gap, output int waits);
    bit took;
    repeat (gap) begin
      u_i_ready = 1'b0;
      data_in   = DW'($urandom);
      @(posedge clock); #1;
    end
    u_i_ready = 1'b1;
    data_in   = px;
    waits     = 0;
    forever begin
      @(negedge clock);
      took = i_i_ready;
      @(posedge clock); #1;
      if (took) break;
      waits++;
      if (waits > 200) begin
        checkOutput("accept_timeout", waits, 0);
        break;
      end
    end
    u_i_ready = 1'b0;
    data_in   = DW'($urandom);
  endtask

  task automatic send_line(input logic [DW-1:0] px [LW], input int gap, input bit rand_gap,
                           output int first_waits);
    int wt;
    int g;
    first_waits = 0;
    for (int c = 0; c < LW; c++) begin
      g = rand_gap ? int'($urandom_range(0, gap)) : gap;
      applyStimulus(px[c], g, wt);
      if (c == 0) first_waits = wt;
    end
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clock);
      if (sb.size() == 0 && !i_r_ready) break;
      n++;
      if (n > 200) begin
        checkOutput("drain_timeout", sb.size(), 0);
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  // A result is handed over on the next edge when valid and ready are both high.
  always @(negedge clock) begin
    if (!reset && i_r_ready && u_r_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_output", i_r_ready, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("data_out", data_out, mon_e.data);
        checkOutput("eol_out", eol_out, mon_e.eol);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0d checks", num_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    u_i_ready = 1'b0;
    u_r_ready = 1'b1;
    data_in   = '0;
    stop_rand = 1'b0;

    @(negedge clock);
    checkOutput("reset_valid", i_r_ready, 0);
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_eol", eol_out, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle_in_ready", i_i_ready, 1);
    @(posedge clock); #1;

    // Two back-to-back lines; the second starts one cycle late (flush bubble).
    line_px = '{2'd1, 2'd2, 2'd3, 2'd0};
    push_line(line_px);
    send_line(line_px, 0, 1'b0, w);
    checkOutput("first_px_wait", w, 0);
    line_px = '{2'd3, 2'd3, 2'd3, 2'd3};
    push_line(line_px);
    send_line(line_px, 0, 1'b0, w);
    checkOutput("line_bubble", w, 1);
    drain();

    // Downstream stall of 5 cycles right after the first result.
    line_px = '{2'd1, 2'd2, 2'd3, 2'd0};
    push_line(line_px);
    fork
      send_line(line_px, 0, 1'b0, w);
      begin
        stall_n = 0;
        forever begin
          @(posedge clock); #1;
          if (i_r_ready) break;
          stall_n++;
          if (stall_n > 50) begin
            checkOutput("stall_start_timeout", stall_n, 0);
            break;
          end
        end
        u_r_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          checkOutput("stall_data", data_out, 4);
          checkOutput("stall_valid", i_r_ready, 1);
          checkOutput("stall_in_ready", i_i_ready, 0);
        end
        @(posedge clock); #1;
        u_r_ready = 1'b1;
      end
    join
    drain();

    // Upstream gaps on alternate cycles.
    line_px = '{2'd2, 2'd0, 2'd1, 2'd1};
    push_line(line_px);
    send_line(line_px, 1, 1'b0, w);
    drain();

    // Reset mid-line discards the partial line and the pending result.
    u_r_ready = 1'b0;
    applyStimulus(2'd1, 0, w);
    applyStimulus(2'd2, 0, w);
    @(negedge clock);
    checkOutput("pre_reset_valid", i_r_ready, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_reset_valid", i_r_ready, 0);
    checkOutput("mid_reset_data", data_out, 0);
    @(posedge clock); #1;
    reset     = 1'b0;
    u_r_ready = 1'b1;
    line_px = '{2'd0, 2'd1, 2'd2, 2'd3};
    push_line(line_px);
    send_line(line_px, 0, 1'b0, w);
    checkOutput("post_reset_wait", w, 0);
    drain();

    // Random valid/ready stress.
    fork
      begin
        for (int l = 0; l < 100; l++) begin
          for (int c = 0; c < LW; c++) line_px[c] = DW'($urandom);
          push_line(line_px);
          send_line(line_px, 2, 1'b1, w);
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clock); #1;
          u_r_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    u_r_ready = 1'b1;
    drain();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
